// File: rtl/divrem_iter.sv
// divrem_iter -- iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
//
// Operands are captured on StartE in IDLE. Signed operations are folded onto an
// unsigned core by taking absolute values and fixing the signs afterwards. One
// quotient bit is produced per ITER cycle. The pipeline hazard logic stalls on
// Busy, and the Memory stage releases DONE by dropping StallM.
//
// Optional feature macro: DIVREM_WORD_OPS_EN (XLEN=64 only). When defined,
// W64E=1 runs a 32-bit operation (DIVW etc.) whose result is sign-extended.
// When undefined, W64E is ignored.
//
// Ports:
//   clk            in   clock, rising edge
//   reset_n        in   synchronous active-low reset
//   StallM         in   holds DONE (and Result) while high
//   FlushE         in   abort any operation, return to IDLE
//   StartE         in   start request, sampled in IDLE only
//   Funct3E[2:0]   in   100 div, 101 divu, 110 rem, 111 remu
//   W64E           in   word operation select
//   ForwardedSrcAE in   dividend
//   ForwardedSrcBE in   divisor
//   Busy           out  INIT, ITER or FIXUP
//   Done           out  Result valid (DONE state)
//   Result         out  quotient or remainder
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for StartE
// INIT   | absolute values, sign capture, divide-by-zero short cut
// ITER   | one shift/trial-subtract step per cycle, N cycles
// FIXUP  | restore signs, pick quotient or remainder
// DONE   | Result valid, held while StallM
module divrem_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StallM,
  input  logic            FlushE,
  input  logic            StartE,
  input  logic [2:0]      Funct3E,
  input  logic            W64E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_sign_q;
  logic            r_sign_r;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;

  logic            w_word;
  logic            w_signed;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_q_init;
  logic            w_div0;
  logic [XLEN:0]   w_rsh;
  logic [XLEN:0]   w_trial;
  logic            w_ge;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_res_raw;
  logic [XLEN-1:0] w_res_fin;
  logic            w_unused_f3;

  assign w_unused_f3 = Funct3E[2];
  assign w_signed    = ~r_op[0];

`ifdef DIVREM_WORD_OPS_EN
  logic r_word;

  assign w_word = r_word;

  always_comb begin
    w_a_ext = r_a;
    w_b_ext = r_b;
    if (r_word) begin
      w_a_ext = {{(XLEN-32){w_signed & r_a[31]}}, r_a[31:0]};
      w_b_ext = {{(XLEN-32){w_signed & r_b[31]}}, r_b[31:0]};
    end
  end

  // A word dividend sits in the upper half of Q so that 32 shifts bring it
  // fully through R; the quotient then lands zero-extended in Q.
  assign w_q_init  = r_word ? {w_abs_a[31:0], {(XLEN-32){1'b0}}} : w_abs_a;
  assign w_res_fin = r_word ? {{(XLEN-32){w_res_raw[31]}}, w_res_raw[31:0]} : w_res_raw;
`else
  logic w_unused_w64;

  assign w_unused_w64 = W64E;
  assign w_word       = 1'b0;
  assign w_a_ext      = r_a;
  assign w_b_ext      = r_b;
  assign w_q_init     = w_abs_a;
  assign w_res_fin    = w_res_raw;
`endif

  assign w_sign_a = w_signed & w_a_ext[XLEN-1];
  assign w_sign_b = w_signed & w_b_ext[XLEN-1];
  // |MIN| wraps back to MIN, which read as unsigned is the correct magnitude.
  assign w_abs_a  = w_sign_a ? -w_a_ext : w_a_ext;
  assign w_abs_b  = w_sign_b ? -w_b_ext : w_b_ext;
  assign w_div0   = (w_b_ext == '0);

  // R < D always holds, so R shifted with the next dividend bit fits in
  // XLEN+1 bits and the trial difference sign is its top bit.
  assign w_rsh   = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_rsh - {1'b0, r_dvs};
  assign w_ge    = ~w_trial[XLEN];

  assign w_q_fix = r_sign_q ? -r_quo : r_quo;
  assign w_r_fix = r_sign_r ? -r_rem : r_rem;

  always_comb begin
    w_res_raw = r_op[1] ? w_r_fix : w_q_fix;
    if (r_state == S_INIT) begin
      w_res_raw = r_op[1] ? w_a_ext : '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (StartE) w_state_nxt = S_INIT;
      end
      S_INIT: begin
        Busy        = 1'b1;
        w_state_nxt = w_div0 ? S_DONE : S_ITER;
      end
      S_ITER: begin
        Busy = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        Busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        if (!StallM) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (FlushE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
`ifdef DIVREM_WORD_OPS_EN
      r_word   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (StartE && !FlushE) begin
            r_a  <= ForwardedSrcAE;
            r_b  <= ForwardedSrcBE;
            r_op <= Funct3E[1:0];
`ifdef DIVREM_WORD_OPS_EN
            r_word <= W64E;
`endif
          end
        end
        S_INIT: begin
          r_rem    <= '0;
          r_quo    <= w_q_init;
          r_dvs    <= w_abs_b;
          r_sign_q <= w_sign_a ^ w_sign_b;
          r_sign_r <= w_sign_a;
          r_cnt    <= w_word ? CW'(31) : CW'(XLEN-1);
          if (w_div0 && !FlushE) r_result <= w_res_fin;
        end
        S_ITER: begin
          r_rem <= w_ge ? w_trial[XLEN-1:0] : w_rsh[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIXUP: begin
          if (!FlushE) r_result <= w_res_fin;
        end
        default: ;
      endcase
    end
  end

  assign Result = r_result;

endmodule

// File: tb/tb_divrem_iter.sv
module tb_divrem_iter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StallM = 1'b0;
  logic        FlushE = 1'b0;
  logic        StartE = 1'b0;
  logic [2:0]  Funct3E = 3'b000;
  logic        W64E = 1'b0;
  logic [63:0] SrcA = '0;
  logic [63:0] SrcB = '0;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;

  divrem_iter #(.XLEN(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .StallM         (StallM),
    .FlushE         (FlushE),
    .StartE         (StartE),
    .Funct3E        (Funct3E),
    .W64E           (W64E),
    .ForwardedSrcAE (SrcA),
    .ForwardedSrcBE (SrcB),
    .Busy           (Busy),
    .Done           (Done),
    .Result         (Result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          start;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] last_res = '0;
  bit          prev_done = 1'b0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] NEG1  = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] op);
    longint sa = a;
    longint sb = b;
    case (op)
      2'b00:   return (b == 0) ? NEG1 : ((a == MIN64 && b == NEG1) ? MIN64 : 64'(sa / sb));
      2'b01:   return (b == 0) ? NEG1 : a / b;
      2'b10:   return (b == 0) ? a : ((a == MIN64 && b == NEG1) ? 64'd0 : 64'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    int sa = a;
    int sb = b;
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF :
                      ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a :
                      ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard monitor: one pop per rising Done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (Done && !prev_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", {63'd0, Done}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", Result, e.res);
          chk("done_cycle", 64'(cyc - e.start + 1), 64'(e.lat));
        end
      end
      prev_done = Done;
    end
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                        input logic w, input int stall);
    logic        wm;
    logic [63:0] r;
    int          lat;
    int          k;
    int          busy_cnt;
`ifdef DIVREM_WORD_OPS_EN
    wm = w;
`else
    wm = 1'b0;
`endif
    if (wm) begin
      r   = {{32{ref32(a[31:0], b[31:0], f[1:0])}}, ref32(a[31:0], b[31:0], f[1:0])};
      r   = {{32{r[31]}}, r[31:0]};
      lat = (b[31:0] == 0) ? 2 : 35;
    end else begin
      r   = ref64(a, b, f[1:0]);
      lat = (b == 0) ? 2 : 67;
    end
    @(negedge clk);
    SrcA = a; SrcB = b; Funct3E = f; W64E = w; StartE = 1'b1; StallM = (stall > 0);
    sb_q.push_back('{res: r, start: cyc + 1, lat: lat});
    k = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      k++;
      StartE = 1'b0;
      SrcA = {$urandom, $urandom};
      SrcB = {$urandom, $urandom};
      Funct3E = {1'b1, 2'($urandom_range(0, 3))};
      W64E = ~w;
      if (Busy) busy_cnt++;
    end while (!Done && k < 200);
    if (!Done) chk("done_timeout", {63'd0, Done}, 64'd1);
    chk("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
    last_res = r;
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        chk("stall_done", {63'd0, Done}, 64'd1);
        chk("stall_result", Result, r);
      end
      StallM = 1'b0;
    end
    @(negedge clk);
    chk("idle_after_done", {62'd0, Busy, Done}, 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    int          mode;

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    chk("reset_result", Result, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(64'd100, 64'd7, 3'b101, 1'b0, 0);
    chk("divu_100_7", Result, 64'd14);
    run_op(64'd100, 64'd7, 3'b111, 1'b0, 0);
    run_op(-64'sd7, 64'd2, 3'b100, 1'b0, 0);
    run_op(-64'sd7, 64'd2, 3'b110, 1'b0, 0);
    run_op(64'd7, -64'sd2, 3'b110, 1'b0, 0);
    run_op(64'd5, 64'd0, 3'b100, 1'b0, 0);
    run_op(64'd5, 64'd0, 3'b111, 1'b0, 0);
    run_op(-64'sd5, 64'd0, 3'b110, 1'b0, 0);
    run_op(MIN64, NEG1, 3'b100, 1'b0, 0);
    run_op(MIN64, NEG1, 3'b110, 1'b0, 0);
    run_op(NEG1, 64'd1, 3'b101, 1'b0, 0);
    run_op(64'd0, 64'd5, 3'b100, 1'b0, 0);

    // Flush during ITER: no Done, Result unchanged, then a fresh op.
    @(negedge clk);
    SrcA = 64'h1234_5678_9ABC_DEF0; SrcB = 64'd3; Funct3E = 3'b101; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    chk("flush_busy", {63'd0, Busy}, 64'd0);
    chk("flush_done", {63'd0, Done}, 64'd0);
    chk("flush_result_kept", Result, last_res);
    repeat (70) @(negedge clk);
    chk("flush_no_done", {62'd0, Busy, Done}, 64'd0);
    run_op(64'd9, 64'd3, 3'b101, 1'b0, 0);

    // Flush beats start in IDLE.
    @(negedge clk);
    SrcA = 64'd50; SrcB = 64'd5; StartE = 1'b1; FlushE = 1'b1;
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    chk("flush_start_idle", {63'd0, Busy}, 64'd0);
    @(negedge clk);
    chk("flush_start_idle2", {63'd0, Busy}, 64'd0);

    run_op(64'd1000, 64'd33, 3'b100, 1'b0, 5);
    run_op(-64'sd1000, 64'd0, 3'b110, 1'b0, 3);

`ifdef DIVREM_WORD_OPS_EN
    run_op(64'h0000_0000_8000_0000, NEG1, 3'b100, 1'b1, 0);
    chk("divw_overflow", Result, 64'hFFFF_FFFF_8000_0000);
    run_op(64'h0000_0000_8000_0000, NEG1, 3'b110, 1'b1, 0);
    run_op(64'hDEAD_0000_FFFF_FFF9, 64'h1234_5678_0000_0002, 3'b100, 1'b1, 0);
    run_op(64'hDEAD_0000_FFFF_FFF9, 64'h1234_5678_0000_0002, 3'b111, 1'b1, 0);
    run_op(64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 3'b111, 1'b1, 0);
`endif

    // Reset in the middle of an operation.
    @(negedge clk);
    SrcA = 64'd77; SrcB = 64'd4; Funct3E = 3'b101; StartE = 1'b1;
    @(negedge clk);
    StartE = 1'b0;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_busy", {63'd0, Busy}, 64'd0);
    chk("midreset_done", {63'd0, Done}, 64'd0);
    chk("midreset_result", Result, 64'd0);
    reset_n = 1'b1;
    last_res = '0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 5);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (mode)
        0: b = '0;
        1: begin a = MIN64; b = NEG1; end
        2: b = 64'($urandom_range(1, 20));
        3: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 40)); end
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) b = -b;
      run_op(a, b, {1'b1, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)), 0);
      if (mode == 4) begin
        run_op({32'($urandom), 32'h8000_0000}, {32'($urandom), 32'hFFFF_FFFF},
               {1'b1, 2'($urandom_range(0, 3))}, 1'b1, 0);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
